polar_frozen_inserter: RTL and testbench
========================================

Name: polar_frozen_inserter

Overview:
- Upstream neighbour of the combinational polar encoder.
- Accepts a frame of K information bits serially over a valid/ready stream and places them in the non-frozen positions of an N-bit u vector. Frozen positions are forced to 0.
- Presents the completed u vector, registered, on a valid/ready output that feeds the encoder's u input directly.

Parameters:
- N, 8, code length; power of two, N >= 2.
- K, 4, information bits per frame; 1 <= K <= N.
- FROZEN_MASK, 8'b0001_0111, N-bit mask; bit i = 1 means position i is frozen. Popcount of ~FROZEN_MASK must equal K (elaboration-time assertion).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- in_bit  in  1  information bit.
- in_valid  in  1  in_bit valid.
- in_ready  out  1  block can accept in_bit.
- frame_abort  in  1  synchronous; discard the partial frame.
- u_vec  out  N  assembled u vector; index i = polar position i.
- out_valid  out  1  u_vec valid.
- out_ready  in  1  downstream accepts u_vec.
- busy  out  1  high while a frame is partially filled (info_cnt != 0).

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values:
  - State = FILL; info_cnt = 0; assembly register = 0.
  - u_vec = 0; out_valid = 0; in_ready = 1; busy = 0.
- FSM has two states, FILL and HOLD.
- FILL:
  - in_ready = 1, out_valid = 0.
  - On in_valid & in_ready: in_bit is written to assembly[POS(info_cnt)], and info_cnt increments.
  - POS(k) is the k-th zero bit of FROZEN_MASK in ascending index order.
  - When the K-th bit is accepted (info_cnt == K-1), the next-cycle values are: u_vec = assembly including this bit, out_valid = 1, state = HOLD, info_cnt = 0.
- HOLD:
  - in_ready = 0; u_vec and out_valid held stable until out_ready.
  - On out_valid & out_ready: next cycle out_valid = 0, state = FILL, assembly cleared to 0.
  - No same-cycle bypass: in_ready stays 0 during the handshake cycle.
- Latency: u_vec is valid the cycle after the last information bit is accepted.
- Throughput: at most one frame per K+1 cycles.
- Frozen positions are always 0 in u_vec, regardless of input.
- Unwritten positions are always 0, because assembly is cleared at each frame start.
- frame_abort:
  - In FILL: info_cnt and assembly cleared next cycle; an in_bit presented in the same cycle is discarded. in_ready stays 1.
  - In HOLD: ignored; a completed frame is never dropped.
- in_valid while in_ready = 0 has no effect. The upstream must hold in_bit until it is accepted.
- K == N (no frozen bits): the block degenerates to a serial-to-parallel converter with identical timing.
- rst asserted mid-frame or mid-HOLD: all state returns to reset values immediately, and the pending frame is lost.
- info_cnt width: $clog2(K+1). It never exceeds K-1 in FILL.

Decomposition:
- Shared package polar_pkg holds:
  - function info_positions(mask, N), returning an array of K position indices, evaluated at elaboration time.
  - function popcount used for the K-consistency assertion.
  - state enum typedef {FILL, HOLD}.
- POS is a constant lookup table indexed by info_cnt.
- No sub-module is required. The lookup table is inline, generated from the package function.

Test Plan:
- Nominal, N=8, K=4, mask 8'b0001_0111:
  - Stimulus: bits 1,0,1,1 on consecutive cycles, out_ready = 1.
  - Response: cycle after the 4th accept, u_vec = 8'hC8 and out_valid = 1 for exactly one cycle; in_ready = 0 that cycle and 1 the next.
- Backpressure:
  - Stimulus: same frame with out_ready held 0 for 5 cycles.
  - Response: u_vec stays 8'hC8, out_valid stays 1, in_ready stays 0 throughout; handshake completes on the first cycle out_ready = 1.
- Frozen enforcement:
  - Stimulus: bits 1,1,1,1.
  - Response: u_vec = 8'hE8 (positions 0,1,2,4 zero). Next frame 0,0,0,0 gives u_vec = 8'h00, proving the assembly register was cleared.
- Abort:
  - Stimulus: accept bits 1,1, pulse frame_abort, then send 0,0,1,0.
  - Response: u_vec = 8'h40; busy drops the cycle after the abort.
- Async reset mid-frame:
  - Stimulus: assert rst between clock edges after 2 accepted bits.
  - Response: out_valid = 0, u_vec = 0, in_ready = 1, busy = 0 immediately. A full subsequent frame 1,0,1,1 yields 8'hC8.
- Back-to-back with random in_valid gaps, K=N=8:
  - Stimulus: 8 bits 1,0,1,0,1,1,0,0.
  - Response: u_vec = 8'h35; a scoreboard passes u_vec through the reference polar encoder and compares.

Source files
------------

// File: rtl/polar_pkg.sv
// rtl/polar_pkg.sv - shared types and elaboration-time helpers for the polar frozen-bit inserter
package polar_pkg;

   localparam int MAX_N = 256;
   localparam int POS_W = 8;

   typedef logic [MAX_N-1:0]            mask_t;
   typedef logic [MAX_N-1:0][POS_W-1:0] pos_tab_t;

   typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;

   function automatic int popcount(input mask_t mask, input int n);
      int cnt;
      cnt = 0;
      for (int i = 0; i < n; i++)
         if (mask[i])
            cnt++;
      return cnt;
   endfunction

   // Entry k holds the index of the k-th zero (information) bit of mask, ascending.
   function automatic pos_tab_t info_positions(input mask_t mask, input int n);
      pos_tab_t pos;
      int k;
      pos = '0;
      k = 0;
      for (int i = 0; i < n; i++) begin
         if (!mask[i]) begin
            pos[k] = POS_W'(i);
            k++;
         end
      end
      return pos;
   endfunction

endpackage

// File: rtl/polar_frozen_inserter.sv
// rtl/polar_frozen_inserter.sv - serial info bits into non-frozen positions of a registered u vector
module polar_frozen_inserter
   import polar_pkg::*;
#(
   parameter int N = 8,
   parameter int K = 4,
   parameter logic [N-1:0] FROZEN_MASK = 8'b0001_0111
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_bit,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         frame_abort,
   output logic [N-1:0] u_vec,
   output logic         out_valid,
   input  logic         out_ready,
   output logic         busy
);

   localparam int CNT_W = $clog2(K + 1);
   localparam int IDX_W = $clog2(N);
   localparam pos_tab_t POS_TAB = info_positions(mask_t'(FROZEN_MASK), N);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(K - 1);

   if (popcount(mask_t'(~FROZEN_MASK), N) != K) begin : g_bad_mask
      $error("FROZEN_MASK information-bit count does not match K");
   end

   state_t           state;
   logic [CNT_W-1:0] info_cnt;
   logic [N-1:0]     assembly;
   logic [N-1:0]     asm_next;
   logic [IDX_W-1:0] pos_cur;

   always_comb begin
      pos_cur  = POS_TAB[info_cnt][IDX_W-1:0];
      asm_next = assembly;
      asm_next[pos_cur] = in_bit;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= FILL;
         info_cnt  <= '0;
         assembly  <= '0;
         u_vec     <= '0;
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
         busy      <= 1'b0;
      end else begin
         case (state)
            FILL: begin
               if (frame_abort) begin
                  info_cnt <= '0;
                  assembly <= '0;
                  busy     <= 1'b0;
               end else if (in_valid) begin
                  if (info_cnt == LAST_CNT) begin
                     u_vec     <= asm_next;
                     assembly  <= asm_next;
                     out_valid <= 1'b1;
                     in_ready  <= 1'b0;
                     info_cnt  <= '0;
                     busy      <= 1'b0;
                     state     <= HOLD;
                  end else begin
                     assembly <= asm_next;
                     info_cnt <= info_cnt + 1'b1;
                     busy     <= 1'b1;
                  end
               end
            end
            HOLD: begin
               // The next frame starts from a clean vector so unwritten positions read 0.
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  assembly  <= '0;
                  state     <= FILL;
               end
            end
            default: state <= FILL;
         endcase
      end
   end

endmodule

// File: tb/tb_polar_frozen_inserter.sv
// tb/tb_polar_frozen_inserter.sv - directed self-checking bench for polar_frozen_inserter
module tb_polar_frozen_inserter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;

   logic       in_bit = 1'b0, in_valid = 1'b0, frame_abort = 1'b0, out_ready = 1'b1;
   logic       in_ready, out_valid, busy;
   logic [7:0] u_vec;

   logic       b_in_bit = 1'b0, b_in_valid = 1'b0, b_frame_abort = 1'b0, b_out_ready = 1'b1;
   logic       b_in_ready, b_out_valid, b_busy;
   logic [7:0] b_u_vec;

   int n_pass = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   polar_frozen_inserter #(.N(8), .K(4), .FROZEN_MASK(8'b0001_0111)) dut (
      .clk(clk), .rst(rst), .in_bit(in_bit), .in_valid(in_valid), .in_ready(in_ready),
      .frame_abort(frame_abort), .u_vec(u_vec), .out_valid(out_valid),
      .out_ready(out_ready), .busy(busy));

   polar_frozen_inserter #(.N(8), .K(8), .FROZEN_MASK(8'b0000_0000)) dut_full (
      .clk(clk), .rst(rst), .in_bit(b_in_bit), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .frame_abort(b_frame_abort), .u_vec(b_u_vec), .out_valid(b_out_valid),
      .out_ready(b_out_ready), .busy(b_busy));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [3:0] bits);
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_bit   = bits[i];
         tick();
      end
      in_valid = 1'b0;
      in_bit   = 1'b0;
   endtask

   function automatic logic [7:0] polar_encode(input logic [7:0] u);
      logic [7:0] x;
      x = u;
      for (int s = 1; s < 8; s = s * 2)
         for (int i = 0; i < 8; i++)
            if ((i & s) == 0)
               x[i] = x[i] ^ x[i + s];
      return x;
   endfunction

   initial begin
      logic [7:0] full_bits;
      logic [7:0] exp_u;

      #12;
      chk("reset_u_vec", 32'(u_vec), 32'h00);
      chk("reset_out_valid", 32'(out_valid), 32'd0);
      chk("reset_in_ready", 32'(in_ready), 32'd1);
      chk("reset_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      tick();

      // Nominal: bits 1,0,1,1 (first bit sent goes to position 3)
      in_valid = 1'b1; in_bit = 1'b1; tick();
      chk("nom_busy_after_first", 32'(busy), 32'd1);
      in_bit = 1'b0; tick();
      in_bit = 1'b1; tick();
      in_bit = 1'b1; tick();
      in_valid = 1'b0;
      chk("nom_u_vec", 32'(u_vec), 32'hC8);
      chk("nom_out_valid", 32'(out_valid), 32'd1);
      chk("nom_in_ready_hold", 32'(in_ready), 32'd0);
      tick();
      chk("nom_out_valid_drop", 32'(out_valid), 32'd0);
      chk("nom_in_ready_back", 32'(in_ready), 32'd1);

      // Backpressure, with an ignored in_valid during HOLD
      out_ready = 1'b0;
      send_frame(4'b1101);
      for (int c = 0; c < 5; c++) begin
         in_valid = 1'b1; in_bit = 1'b1;
         chk($sformatf("bp_u_vec_%0d", c), 32'(u_vec), 32'hC8);
         chk($sformatf("bp_out_valid_%0d", c), 32'(out_valid), 32'd1);
         chk($sformatf("bp_in_ready_%0d", c), 32'(in_ready), 32'd0);
         tick();
      end
      in_valid = 1'b0; in_bit = 1'b0;
      out_ready = 1'b1;
      tick();
      chk("bp_release_out_valid", 32'(out_valid), 32'd0);
      chk("bp_release_in_ready", 32'(in_ready), 32'd1);
      chk("bp_release_busy", 32'(busy), 32'd0);

      // Frozen enforcement, then clear check
      send_frame(4'b1111);
      chk("frozen_ones", 32'(u_vec), 32'hE8);
      tick();
      send_frame(4'b0000);
      chk("frozen_zeros", 32'(u_vec), 32'h00);
      chk("frozen_zeros_valid", 32'(out_valid), 32'd1);
      tick();

      // Abort after two bits; the bit in the abort cycle is dropped
      in_valid = 1'b1; in_bit = 1'b1; tick(); tick();
      frame_abort = 1'b1; tick();
      frame_abort = 1'b0; in_valid = 1'b0;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_in_ready", 32'(in_ready), 32'd1);
      send_frame(4'b0100);
      chk("abort_u_vec", 32'(u_vec), 32'h40);
      tick();

      // Async reset between edges after two accepted bits
      in_valid = 1'b1; in_bit = 1'b1; tick();
      in_bit = 1'b0; tick();
      in_valid = 1'b0;
      chk("arst_busy_before", 32'(busy), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("arst_out_valid", 32'(out_valid), 32'd0);
      chk("arst_u_vec", 32'(u_vec), 32'h00);
      chk("arst_in_ready", 32'(in_ready), 32'd1);
      chk("arst_busy", 32'(busy), 32'd0);
      #1 rst = 1'b0;
      tick();
      send_frame(4'b1101);
      chk("arst_next_u_vec", 32'(u_vec), 32'hC8);
      chk("arst_next_valid", 32'(out_valid), 32'd1);
      tick();

      // K == N serial-to-parallel with random gaps
      full_bits = 8'b0011_0101;
      exp_u     = 8'h35;
      for (int i = 0; i < 8; i++) begin
         int gap;
         gap = $urandom_range(0, 2);
         b_in_valid = 1'b0;
         for (int g = 0; g < gap; g++) tick();
         b_in_valid = 1'b1;
         b_in_bit   = full_bits[i];
         tick();
         if (i < 7)
            chk($sformatf("full_no_early_valid_%0d", i), 32'(b_out_valid), 32'd0);
      end
      b_in_valid = 1'b0;
      chk("full_out_valid", 32'(b_out_valid), 32'd1);
      chk("full_u_vec", 32'(b_u_vec), 32'(exp_u));
      chk("full_encoded", 32'(polar_encode(b_u_vec)), 32'(polar_encode(exp_u)));
      tick();
      chk("full_out_valid_drop", 32'(b_out_valid), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
